sampdecimate: RTL and testbench
===============================

Name: sampdecimate

Overview:
- Per-channel sample decimator between an adcchannel sample output and the sampselect input.
- Reduces the 125 MHz sample stream by 2^k in one of three modes: subsample, per-lane average, or min/max peak envelope.
- Lets long captures fit in the sampleq buffer.
- Configured over the fast-clock wishbone bus through busdispatch.
- Input and output words are 32 bits: four 8-bit ADC readings, byte lane 0 = oldest.

Parameters:
- MAX_LOG2, 7, largest accepted decimation exponent; ratio = 2^log2, up to 128.

Ports:
- clk  in  1  main 125 MHz clock
- rst  in  1  synchronous active-high reset
- sq_active  in  1  capture active; low discards any partial window
- sample  in  32  sample word from adcchannel
- sample_avail  in  1  sample valid strobe, one cycle per word
- dec_sample  out  32  decimated word to sampselect
- dec_sample_avail  out  1  one-cycle valid strobe for dec_sample
- wb_stb_i  in  1  wishbone strobe
- wb_cyc_i  in  1  wishbone cycle
- wb_we_i  in  1  wishbone write enable
- wb_adr_i  in  16  register address; only bits [1:0] decoded
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data
- wb_ack_o  out  1  one-cycle acknowledge

Behaviour:
- Reset values:
  - all outputs 0
  - ctrl = 0: mode pass-through, enable 0
  - log2 = 0
  - window counter and accumulators cleared
- Registers:
  - 0: ctrl. bit0 = enable, bits[2:1] = mode (0 pass, 1 subsample, 2 average, 3 peak).
  - 1: log2. Writes above MAX_LOG2 clamp to MAX_LOG2.
  - 2: status, read-only. bit0 = window in progress, bits[7:1] = count[6:0].
  - 3: reads 0.
- Wishbone:
  - wb_ack_o pulses high the cycle after stb&cyc&!ack.
  - wb_dat_o is valid with the ack.
  - Writes to regs 0 and 1 clear the window counter and all accumulators.
  - Writes to reg 2 are ignored but acked.
- Enable = 0 or mode 0:
  - dec_sample = sample and dec_sample_avail = sample_avail, both registered.
  - Latency 1 cycle.
- Window:
  - count runs 0..2^log2-1, advancing on each sample_avail while sq_active and enabled.
  - Wraps to 0 after the last word.
  - log2 = 0 gives a window of 1 word, so every mode equals pass-through except the 1-cycle latency.
- Mode 1, subsample: emit the word that arrives at count==0. Output 1 cycle after that input.
- Mode 2, average:
  - Four 15-bit unsigned lane accumulators.
  - On the last word of a window, emit per lane (acc + lane) >> log2, truncated, low 8 bits.
  - The accumulator is then reloaded with 0, not with the current word.
  - Output 1 cycle after the last input.
- Mode 3, peak (only with the macro):
  - Per-lane running max on even windows and running min on odd windows.
  - Emit at window end; the even/odd flag toggles on each emission.
  - The flag clears on config write or !sq_active.
- sq_active low:
  - Counter, accumulators and peak flag clear.
  - No output is emitted.
  - sample_avail is ignored, except in pass-through, which still forwards.
- Simultaneous wishbone write and sample_avail: the write wins and that sample is dropped.
- sq_active rising: the first window starts at count 0 with the next sample_avail.
- Back-to-back sample_avail every cycle must be sustained with no drops. Throughput is 1 word/clk.

Optional Feature:
- Macro: SAMPDECIMATE_PEAK_EN
- Defined: mode 3 implements the min/max envelope above.
- Undefined: mode 3 behaves exactly as mode 1 (subsample), no min/max logic is built, and ctrl reads back the written mode bits unchanged.

Test Plan:
- Reset, then read regs 0/1/2 -> all return 0x00. dec_sample_avail stays 0 while samples stream in mode 0 with enable = 0, and dec_sample equals input delayed 1 clk.
- Mode 1, log2 = 2, enable, sq_active = 1, feed words 0x00..0x07 on consecutive clks -> exactly two outputs: 0x00000000 one clk after word 0, and 0x00000004 one clk after word 4.
- Mode 2, log2 = 1, feed 0x10203040 then 0x12223242 -> one output 0x11213141, 1 clk after the second word. Then feed 0xFFFFFFFF twice -> 0xFFFFFFFF (no overflow).
- Mode 2, log2 = 3, feed 5 words, drop sq_active for 1 clk, re-raise, feed 8 words of 0x01010101 -> single output 0x01010101, the partial window discarded.
- With SAMPDECIMATE_PEAK_EN, mode 3, log2 = 1, feed 0x05, 0x09, 0x05, 0x09 (lane 0) -> outputs lane0 0x09 (max), then 0x05 (min).
- Write log2 = 0xFF -> readback 0x07. A write to ctrl in the same cycle as sample_avail in mode 2 drops that word and clears the accumulators; the next 2^log2 words produce a clean average.

Source files
------------

// File: rtl/sampdecimate.sv
// sampdecimate: 2^log2 sample decimator (pass, subsample, per-lane average; min/max peak envelope
// in mode 3 when SAMPDECIMATE_PEAK_EN is defined, otherwise mode 3 subsamples) with a wishbone register port.
module sampdecimate #(
  parameter int MAX_LOG2 = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sq_active,
  input  logic [31:0] sample,
  input  logic        sample_avail,
  output logic [31:0] dec_sample,
  output logic        dec_sample_avail,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);
  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int AW = 8 + MAX_LOG2;
  logic                enable, last, emit, pass, req, wr, wr_cfg, adv, adr_unused;
  logic [1:0]          mode;
  logic [LW-1:0]       log2;
  logic [MAX_LOG2-1:0] count;
  logic [AW-1:0]       acc [4];
  logic [AW-1:0]       sum [4];
  logic [31:0]         avg_word, emit_word;
  logic [7:0]          rd_data;
  assign adr_unused = ^wb_adr_i[15:2];
  assign req        = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr         = req & wb_we_i;
  assign wr_cfg     = wr & ~wb_adr_i[1];
  assign pass       = ~enable | (mode == 2'd0);
  // a config write in the same cycle takes priority and drops the sample
  assign adv        = sample_avail & sq_active & ~wr_cfg & ~pass;
  assign last       = 32'(count) == (32'd1 << log2) - 32'd1;
  assign rd_data    = wb_adr_i[1:0] == 2'd0 ? {5'd0, mode, enable} :
                      wb_adr_i[1:0] == 2'd1 ? 8'(log2) :
                      wb_adr_i[1:0] == 2'd2 ? {7'(count), count != '0} : 8'd0;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_lane
    assign sum[i]             = acc[i] + AW'(sample[8*i +: 8]);
    assign avg_word[8*i +: 8] = 8'(sum[i] >> log2);
  end
`ifdef SAMPDECIMATE_PEAK_EN
  logic       odd;
  logic [7:0] pk [4];
  logic [31:0] pk_word;
  genvar j;
  for (j = 0; j < 4; j++) begin : g_pk
    logic [7:0] v;
    assign v                 = sample[8*j +: 8];
    assign pk_word[8*j +: 8] = count == '0 ? v :
                               odd ? (v < pk[j] ? v : pk[j]) : (v > pk[j] ? v : pk[j]);
  end
  assign emit      = mode == 2'd1 ? count == '0 : last;
  assign emit_word = mode == 2'd1 ? sample : mode == 2'd2 ? avg_word : pk_word;
`else
  assign emit      = mode == 2'd2 ? last : count == '0;
  assign emit_word = mode == 2'd2 ? avg_word : sample;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      enable           <= 1'b0;
      mode             <= 2'd0;
      log2             <= '0;
      count            <= '0;
      acc              <= '{default: '0};
      wb_ack_o         <= 1'b0;
      wb_dat_o         <= 8'd0;
      dec_sample       <= 32'd0;
      dec_sample_avail <= 1'b0;
`ifdef SAMPDECIMATE_PEAK_EN
      odd              <= 1'b0;
      pk               <= '{default: '0};
`endif
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd_data : 8'd0;
      if (wr && wb_adr_i[1:0] == 2'd0) {mode, enable} <= wb_dat_i[2:0];
      if (wr && wb_adr_i[1:0] == 2'd1) log2 <= wb_dat_i > 8'(MAX_LOG2) ? LW'(MAX_LOG2) : wb_dat_i[LW-1:0];
      dec_sample_avail <= pass ? sample_avail : adv & emit;
      if (pass) dec_sample <= sample;
      else if (adv && emit) dec_sample <= emit_word;
      if (wr_cfg || !sq_active) begin
        count <= '0;
        acc   <= '{default: '0};
`ifdef SAMPDECIMATE_PEAK_EN
        odd   <= 1'b0;
`endif
      end else if (adv) begin
        count <= last ? '0 : count + 1'b1;
        for (int l = 0; l < 4; l++) acc[l] <= last ? '0 : sum[l];
`ifdef SAMPDECIMATE_PEAK_EN
        for (int l = 0; l < 4; l++) pk[l] <= pk_word[8*l +: 8];
        if (last && mode == 2'd3) odd <= ~odd;
`endif
      end
    end
  end
endmodule

// File: tb/tb_sampdecimate.sv
// tb_sampdecimate: randomized and directed checks of sampdecimate against a window-queue reference model.
module tb_sampdecimate;
  logic        clk = 0, rst = 1, sq_active = 0, sample_avail = 0;
  logic        wb_stb_i = 0, wb_cyc_i = 0, wb_we_i = 0;
  logic [31:0] sample = 0;
  logic [15:0] wb_adr_i = 0;
  logic [7:0]  wb_dat_i = 0;
  logic [31:0] dec_sample;
  logic        dec_sample_avail, wb_ack_o;
  logic [7:0]  wb_dat_o;
  int checks = 0, errors = 0;
  int m_mode = 0, m_en = 0, m_k = 0, m_odd = 0;
  logic [31:0] win [$];
`ifdef SAMPDECIMATE_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  always #4 clk = ~clk;

  sampdecimate dut (
    .clk(clk), .rst(rst), .sq_active(sq_active), .sample(sample), .sample_avail(sample_avail),
    .dec_sample(dec_sample), .dec_sample_avail(dec_sample_avail),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  // Reference: collect each window's words in a queue, decide output when the window fills.
  task automatic model(input logic [31:0] w, input bit av, input bit act, output logic e,
                       output logic [31:0] ew, output logic pd);
    int s, v;
    e = 0; ew = '0; pd = 0;
    if (m_en == 0 || m_mode == 0) begin e = av; ew = w; pd = 1; return; end
    if (!act) begin win.delete(); m_odd = 0; return; end
    if (!av) return;
    win.push_back(w);
    if ((m_mode == 1 || (m_mode == 3 && !PEAK)) && win.size() == 1) begin e = 1; ew = w; end
    if (win.size() == (1 << m_k)) begin
      if (m_mode == 2) begin
        e = 1;
        for (int l = 0; l < 4; l++) begin
          s = 0;
          foreach (win[q]) s += int'(win[q][8*l +: 8]);
          ew[8*l +: 8] = 8'(s >> m_k);
        end
      end else if (m_mode == 3 && PEAK) begin
        e = 1;
        for (int l = 0; l < 4; l++) begin
          s = int'(win[0][8*l +: 8]);
          foreach (win[q]) begin
            v = int'(win[q][8*l +: 8]);
            s = (m_odd != 0) ? (v < s ? v : s) : (v > s ? v : s);
          end
          ew[8*l +: 8] = 8'(s);
        end
        m_odd ^= 1;
      end
      win.delete();
    end
    pd = e;
  endtask

  task automatic step(input logic [31:0] w, input bit av, input bit act, output logic ga,
                      output logic [31:0] gd, output logic ea, output logic [31:0] ed, output logic pd);
    sample = w; sample_avail = av; sq_active = act;
    model(w, av, act, ea, ed, pd);
    @(posedge clk); #1;
    ga = dec_sample_avail; gd = dec_sample;
    sample_avail = 0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d, input logic [31:0] w, input bit av,
                          output logic ack, output logic ga);
    wb_adr_i = 16'(a); wb_dat_i = d; wb_we_i = 1; wb_stb_i = 1; wb_cyc_i = 1;
    sample = w; sample_avail = av;
    @(posedge clk); #1;
    ack = wb_ack_o; ga = dec_sample_avail;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0; sample_avail = 0;
    if (a == 0) begin m_en = int'(d[0]); m_mode = int'(d[2:1]); end
    if (a == 1) m_k = d > 7 ? 7 : int'(d);
    if (a < 2 || !sq_active) begin win.delete(); m_odd = 0; end
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] d, output logic ack);
    wb_adr_i = 16'(a); wb_we_i = 0; wb_stb_i = 1; wb_cyc_i = 1;
    @(posedge clk); #1;
    d = wb_dat_o; ack = wb_ack_o;
    wb_stb_i = 0; wb_cyc_i = 0;
    if (!sq_active) begin win.delete(); m_odd = 0; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [7:0] d; logic ack, ga, ea, pd; logic [31:0] gd, ed, w;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dec_sample, dec_sample_avail, wb_dat_o, wb_ack_o} !== 42'd0)
      begin errors++; $display("FAIL reset_outputs got %h/%b/%h/%b exp 0", dec_sample, dec_sample_avail, wb_dat_o, wb_ack_o); end
    rst = 0;
    for (int r = 0; r < 3; r++) begin
      wb_read(2'(r), d, ack);
      checks++;
      if (d !== 8'h00 || ack !== 1'b1)
        begin errors++; $display("FAIL reset_reg%0d got %h ack %b exp 00 ack 1", r, d, ack); end
    end
    for (int n = 0; n < 6; n++) begin
      w = $urandom;
      step(w, 0, 1, ga, gd, ea, ed, pd);
      checks++;
      if (ga !== 1'b0 || gd !== w)
        begin errors++; $display("FAIL reset_stream got %b/%h exp 0/%h", ga, gd, w); end
    end
  endtask

  task automatic test_pass;
    logic ack, ga, ea, pd; logic [31:0] gd, ed;
    foreach (win[q]) win.delete(q);
    for (int c = 0; c < 2; c++) begin
      wb_write(0, c == 0 ? 8'h00 : 8'h04, 0, 0, ack, ga);
      for (int n = 0; n < 10; n++) begin
        step($urandom, 1'($urandom), 1'($urandom), ga, gd, ea, ed, pd);
        checks++;
        if (ga !== ea || (pd && gd !== ed))
          begin errors++; $display("FAIL pass cfg%0d got %b/%h exp %b/%h", c, ga, gd, ea, ed); end
      end
    end
  endtask

  task automatic test_subsample;
    logic ack, ga, ea, pd; logic [31:0] gd, ed; int n;
    sq_active = 1;
    wb_write(0, 8'h03, 0, 0, ack, ga);
    wb_write(1, 8'h02, 0, 0, ack, ga);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(32'(i), 1, 1, ga, gd, ea, ed, pd);
      checks++;
      if (ga !== ea || (pd && gd !== ed))
        begin errors++; $display("FAIL sub_model got %b/%h exp %b/%h", ga, gd, ea, ed); end
      if (ga === 1'b1) begin
        n++;
        checks++;
        if (gd !== 32'(i) || (i % 4) != 0)
          begin errors++; $display("FAIL sub_value got %h at word %0d exp word 0 or 4", gd, i); end
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL sub_count got %0d exp 2", n); end
  endtask

  task automatic test_average;
    logic ack, ga, ea, pd; logic [31:0] gd, ed;
    sq_active = 1;
    wb_write(0, 8'h05, 0, 0, ack, ga);
    wb_write(1, 8'h01, 0, 0, ack, ga);
    step(32'h10203040, 1, 1, ga, gd, ea, ed, pd);
    checks++;
    if (ga !== 1'b0) begin errors++; $display("FAIL avg_first got avail %b exp 0", ga); end
    step(32'h12223242, 1, 1, ga, gd, ea, ed, pd);
    checks++;
    if (ga !== 1'b1 || gd !== 32'h11213141)
      begin errors++; $display("FAIL avg_pair got %b/%h exp 1/11213141", ga, gd); end
    step(32'hFFFFFFFF, 1, 1, ga, gd, ea, ed, pd);
    step(32'hFFFFFFFF, 1, 1, ga, gd, ea, ed, pd);
    checks++;
    if (ga !== 1'b1 || gd !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL avg_ff got %b/%h exp 1/ffffffff", ga, gd); end
    wb_write(1, 8'h07, 0, 0, ack, ga);
    for (int n = 0; n < 128; n++) begin
      step(n < 64 ? 32'hFFFFFFFF : $urandom, 1, 1, ga, gd, ea, ed, pd);
      if (n == 127 || ga !== 1'b0) begin
        checks++;
        if (ga !== ea || (pd && gd !== ed))
          begin errors++; $display("FAIL avg_128 word %0d got %b/%h exp %b/%h", n, ga, gd, ea, ed); end
      end
    end
  endtask

  task automatic test_partial;
    logic ack, ga, ea, pd; logic [31:0] gd, ed; int n;
    sq_active = 1;
    wb_write(0, 8'h05, 0, 0, ack, ga);
    wb_write(1, 8'h03, 0, 0, ack, ga);
    for (int i = 0; i < 5; i++) step($urandom, 1, 1, ga, gd, ea, ed, pd);
    step($urandom, 1, 0, ga, gd, ea, ed, pd);
    checks++;
    if (ga !== 1'b0) begin errors++; $display("FAIL partial_drop got avail %b exp 0", ga); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(32'h01010101, 1, 1, ga, gd, ea, ed, pd);
      if (ga === 1'b1) n++;
    end
    checks++;
    if (n != 1 || gd !== 32'h01010101 || ga !== 1'b1)
      begin errors++; $display("FAIL partial_avg got %0d outputs last %b/%h exp 1 output 01010101", n, ga, gd); end
  endtask

  task automatic test_peak;
    logic ack, ga, ea, pd; logic [31:0] gd, ed;
    logic [31:0] words [4] = '{32'h05, 32'h09, 32'h05, 32'h09};
    sq_active = 1;
    wb_write(0, 8'h07, 0, 0, ack, ga);
    wb_write(1, 8'h01, 0, 0, ack, ga);
    for (int i = 0; i < 4; i++) begin
      step(words[i], 1, 1, ga, gd, ea, ed, pd);
      checks++;
      if (ga !== ea || (pd && gd !== ed))
        begin errors++; $display("FAIL peak_model word %0d got %b/%h exp %b/%h", i, ga, gd, ea, ed); end
      if (i == 1 || i == 3) begin
        checks++;
        if (ga !== 1'b1 || gd !== (i == 1 ? 32'h09 : 32'h05))
          begin errors++; $display("FAIL peak_value word %0d got %b/%h exp 1/%h", i, ga, gd, i == 1 ? 32'h09 : 32'h05); end
      end
    end
  endtask

  task automatic test_clamp_collision;
    logic ack, ga, ea, pd; logic [31:0] gd, ed; logic [7:0] d;
    sq_active = 1;
    wb_write(1, 8'hFF, 0, 0, ack, ga);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", ack); end
    wb_read(1, d, ack);
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL clamp got %h exp 07", d); end
    wb_write(0, 8'h05, 0, 0, ack, ga);
    wb_write(1, 8'h02, 0, 0, ack, ga);
    for (int i = 0; i < 3; i++) step($urandom, 1, 1, ga, gd, ea, ed, pd);
    wb_read(2, d, ack);
    checks++;
    if (d !== 8'(((win.size() << 1) | (win.size() != 0))) || d !== 8'h07)
      begin errors++; $display("FAIL status got %h exp 07", d); end
    wb_write(0, 8'h05, 32'hFFFFFFFF, 1, ack, ga);
    checks++;
    if (ga !== 1'b0) begin errors++; $display("FAIL collide_drop got avail %b exp 0", ga); end
    wb_read(2, d, ack);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL collide_status got %h exp 00", d); end
    for (int i = 0; i < 4; i++) begin
      step($urandom, 1, 1, ga, gd, ea, ed, pd);
      checks++;
      if (ga !== ea || (pd && gd !== ed) || (i == 3 && ga !== 1'b1))
        begin errors++; $display("FAIL collide_avg word %0d got %b/%h exp %b/%h", i, ga, gd, ea, ed); end
    end
  endtask

  task automatic test_random;
    logic ack, ga, ea, pd; logic [31:0] gd, ed;
    for (int c = 0; c < 8; c++) begin
      sq_active = 1;
      wb_write(0, 8'({$urandom_range(1, 3), 1'($urandom_range(0, 5) != 0)}), 0, 0, ack, ga);
      wb_write(1, 8'($urandom_range(0, 3)), 0, 0, ack, ga);
      for (int n = 0; n < 60; n++) begin
        step($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, ga, gd, ea, ed, pd);
        checks++;
        if (ga !== ea || (pd && gd !== ed))
          begin errors++; $display("FAIL random cfg %0d/%0d/%0d got %b/%h exp %b/%h", m_en, m_mode, m_k, ga, gd, ea, ed); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass();
    test_subsample();
    test_average();
    test_partial();
    if (PEAK) test_peak();
    test_clamp_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
